// File: rtl/alert_pkg.sv
// Shared constants and types for the alert handler classifier.
package alert_pkg;

   // Default sizing of the classifier; the top derives its parameter defaults from these.
   localparam int unsigned NAlertsDef    = 4;
   localparam int unsigned NLocAlertsDef = 7;
   localparam int unsigned NClassesDef   = 4;
   localparam int unsigned ClassDwDef    = $clog2(NClassesDef);
   localparam int unsigned CntDwDef      = 16;

   // Class index and per-class hit counter at the default sizing.
   typedef logic [ClassDwDef-1:0] class_idx_t;
   typedef logic [CntDwDef-1:0]   class_cnt_t;

endpackage

// File: rtl/alert_handler_class_cnt.sv
// Per-class saturating hit counter with a synchronous clear.
module alert_handler_class_cnt
   import alert_pkg::*;
#(
   parameter int unsigned CntDw = CntDwDef
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             hit_i,
   input  logic             clr_i,
   output logic [CntDw-1:0] cnt_o,
   output logic             sat_o
);

   logic [CntDw-1:0] cnt_q, cnt_d;
   logic             sat;

   assign sat = (cnt_q == {CntDw{1'b1}});

   // Clear wins over the held count, but a hit in the clear cycle still counts once.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = hit_i ? CntDw'(1) : '0;
      end else if (hit_i && !sat) begin
         cnt_d = cnt_q + CntDw'(1);
      end
   end

   // Counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign sat_o = sat;

endmodule

// File: rtl/alert_handler_classifier.sv
// Alert classifier: shadows and locks configuration, records sticky causes, maps alerts
// to classes and counts per-class hits.
module alert_handler_classifier
   import alert_pkg::*;
#(
   parameter int unsigned NAlerts    = NAlertsDef,
   parameter int unsigned NLocAlerts = NLocAlertsDef,
   parameter int unsigned NClasses   = NClassesDef,
   parameter int unsigned ClassDw    = $clog2(NClasses),
   parameter int unsigned CntDw      = CntDwDef
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NAlerts-1:0]          alert_trig_i,
   input  logic [NLocAlerts-1:0]       loc_alert_trig_i,
   input  logic [NAlerts-1:0]          alert_en_i,
   input  logic [NLocAlerts-1:0]       loc_alert_en_i,
   input  logic [NAlerts*ClassDw-1:0]  alert_class_i,
   input  logic [NLocAlerts*ClassDw-1:0] loc_alert_class_i,
   input  logic [NClasses-1:0]         class_en_i,
   input  logic                        cfg_lock_i,
   input  logic [NAlerts-1:0]          cause_clr_i,
   input  logic [NLocAlerts-1:0]       loc_cause_clr_i,
   input  logic [NClasses-1:0]         class_cnt_clr_i,
   output logic                        cfg_locked_o,
   output logic [NAlerts-1:0]          alert_cause_o,
   output logic [NLocAlerts-1:0]       loc_alert_cause_o,
   output logic [NClasses-1:0]         class_trig_o,
   output logic [NClasses*CntDw-1:0]   class_cnt_o,
   output logic [NClasses-1:0]         class_cnt_sat_o
);

   logic                          locked_q;
   logic [NAlerts-1:0]            en_q;
   logic [NLocAlerts-1:0]         loc_en_q;
   logic [NAlerts*ClassDw-1:0]    class_q;
   logic [NLocAlerts*ClassDw-1:0] loc_class_q;
   logic [NClasses-1:0]           class_en_q;

   logic [NAlerts-1:0]            eff, cause_q, cause_d;
   logic [NLocAlerts-1:0]         loc_eff, loc_cause_q, loc_cause_d;
   logic [NClasses-1:0]           hit, trig_q;

   // Config shadow tracks the inputs until the lock is set, then freezes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         locked_q    <= 1'b0;
         en_q        <= '0;
         loc_en_q    <= '0;
         class_q     <= '0;
         loc_class_q <= '0;
         class_en_q  <= '0;
      end else begin
         locked_q <= locked_q | cfg_lock_i;
         if (!locked_q) begin
            en_q        <= alert_en_i;
            loc_en_q    <= loc_alert_en_i;
            class_q     <= alert_class_i;
            loc_class_q <= loc_alert_class_i;
            class_en_q  <= class_en_i;
         end
      end
   end

   assign eff     = alert_trig_i & en_q;
   assign loc_eff = loc_alert_trig_i & loc_en_q;

   // A new cause beats a clear arriving in the same cycle.
   assign cause_d     = (cause_q & ~cause_clr_i) | eff;
   assign loc_cause_d = (loc_cause_q & ~loc_cause_clr_i) | loc_eff;

   // Class hit: any effective alert mapped to the class; out-of-range indices match nothing.
   always_comb begin
      hit = '0;
      for (int k = 0; k < NClasses; k++) begin
         for (int i = 0; i < NAlerts; i++) begin
            if (eff[i] && (class_q[i*ClassDw +: ClassDw] == ClassDw'(k))) begin
               hit[k] = 1'b1;
            end
         end
         for (int j = 0; j < NLocAlerts; j++) begin
            if (loc_eff[j] && (loc_class_q[j*ClassDw +: ClassDw] == ClassDw'(k))) begin
               hit[k] = 1'b1;
            end
         end
         hit[k] = hit[k] & class_en_q[k];
      end
   end

   // Sticky causes and the one-cycle-delayed class trigger.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cause_q     <= '0;
         loc_cause_q <= '0;
         trig_q      <= '0;
      end else begin
         cause_q     <= cause_d;
         loc_cause_q <= loc_cause_d;
         trig_q      <= hit;
      end
   end

   for (genvar k = 0; k < NClasses; k++) begin : g_cnt
      alert_handler_class_cnt #(
         .CntDw (CntDw)
      ) u_cnt (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .hit_i  (hit[k]),
         .clr_i  (class_cnt_clr_i[k]),
         .cnt_o  (class_cnt_o[k*CntDw +: CntDw]),
         .sat_o  (class_cnt_sat_o[k])
      );
   end

   assign cfg_locked_o      = locked_q;
   assign alert_cause_o     = cause_q;
   assign loc_alert_cause_o = loc_cause_q;
   assign class_trig_o      = trig_q;

endmodule

// File: tb/tb_alert_handler_classifier.sv
// Self-checking bench for alert_handler_classifier (4 classes/4-bit counters, plus a
// 3-class instance for the out-of-range class index case).
module tb_alert_handler_classifier;

   localparam int NA  = 4;
   localparam int NL  = 7;
   localparam int NC  = 4;
   localparam int CD  = 2;
   localparam int CW  = 4;
   localparam int NCB = 3;
   localparam int CWB = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [NC-1:0] trig_exp_q[$];
   logic [CW-1:0] cnt_exp_q[$];
   logic [NC-1:0] trig_exp;
   logic [CW-1:0] cnt_exp;

   // Instance A
   logic [NA-1:0]    a_trig, a_en, a_clr, a_cause;
   logic [NL-1:0]    a_ltrig, a_len, a_lclr, a_lcause;
   logic [NA*CD-1:0] a_class;
   logic [NL*CD-1:0] a_lclass;
   logic [NC-1:0]    a_cen, a_cclr, a_ctrig, a_sat;
   logic             a_lock, a_locked;
   logic [NC*CW-1:0] a_cnt;

   // Instance B
   logic [NA-1:0]      b_trig, b_en, b_clr, b_cause;
   logic [NL-1:0]      b_ltrig, b_len, b_lclr, b_lcause;
   logic [NA*CD-1:0]   b_class;
   logic [NL*CD-1:0]   b_lclass;
   logic [NCB-1:0]     b_cen, b_cclr, b_ctrig, b_sat;
   logic               b_lock, b_locked;
   logic [NCB*CWB-1:0] b_cnt;

   alert_handler_classifier #(
      .NAlerts    (NA),
      .NLocAlerts (NL),
      .NClasses   (NC),
      .ClassDw    (CD),
      .CntDw      (CW)
   ) u_dut_a (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .alert_trig_i      (a_trig),
      .loc_alert_trig_i  (a_ltrig),
      .alert_en_i        (a_en),
      .loc_alert_en_i    (a_len),
      .alert_class_i     (a_class),
      .loc_alert_class_i (a_lclass),
      .class_en_i        (a_cen),
      .cfg_lock_i        (a_lock),
      .cause_clr_i       (a_clr),
      .loc_cause_clr_i   (a_lclr),
      .class_cnt_clr_i   (a_cclr),
      .cfg_locked_o      (a_locked),
      .alert_cause_o     (a_cause),
      .loc_alert_cause_o (a_lcause),
      .class_trig_o      (a_ctrig),
      .class_cnt_o       (a_cnt),
      .class_cnt_sat_o   (a_sat)
   );

   alert_handler_classifier #(
      .NAlerts    (NA),
      .NLocAlerts (NL),
      .NClasses   (NCB)
   ) u_dut_b (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .alert_trig_i      (b_trig),
      .loc_alert_trig_i  (b_ltrig),
      .alert_en_i        (b_en),
      .loc_alert_en_i    (b_len),
      .alert_class_i     (b_class),
      .loc_alert_class_i (b_lclass),
      .class_en_i        (b_cen),
      .cfg_lock_i        (b_lock),
      .cause_clr_i       (b_clr),
      .loc_cause_clr_i   (b_lclr),
      .class_cnt_clr_i   (b_cclr),
      .cfg_locked_o      (b_locked),
      .alert_cause_o     (b_cause),
      .loc_alert_cause_o (b_lcause),
      .class_trig_o      (b_ctrig),
      .class_cnt_o       (b_cnt),
      .class_cnt_sat_o   (b_sat)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs();
      a_trig = '0; a_en = '0; a_clr = '0; a_ltrig = '0; a_len = '0; a_lclr = '0;
      a_class = '0; a_lclass = '0; a_cen = '0; a_cclr = '0; a_lock = 1'b0;
      b_trig = '0; b_en = '0; b_clr = '0; b_ltrig = '0; b_len = '0; b_lclr = '0;
      b_class = '0; b_lclass = '0; b_cen = '0; b_cclr = '0; b_lock = 1'b0;
   endtask

   // Called just after an edge; pulses reset between edges.
   task automatic apply_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      init_inputs();
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({a_locked, a_cause, a_lcause, a_ctrig, a_cnt, a_sat} !== '0) begin
         bad++;
         $display("FAIL reset_a: got %0h want 0",
                  {a_locked, a_cause, a_lcause, a_ctrig, a_cnt, a_sat});
      end
      total++;
      if ({b_locked, b_cause, b_lcause, b_ctrig, b_cnt, b_sat} !== '0) begin
         bad++;
         $display("FAIL reset_b: got %0h want 0",
                  {b_locked, b_cause, b_lcause, b_ctrig, b_cnt, b_sat});
      end
      // Trigger held across release: shadow loads on the first edge, trigger on the second.
      a_en = '1; a_cen = '1; a_class[2*CD +: CD] = 2'd1; a_trig[2] = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (a_ctrig !== 4'b0000) begin
         bad++;
         $display("FAIL first_edge_trig: got %b want 0000", a_ctrig);
      end
      tick();
      total++;
      if (a_ctrig !== 4'b0010) begin
         bad++;
         $display("FAIL second_edge_trig: got %b want 0010", a_ctrig);
      end
      a_trig = '0;
      apply_reset();
   endtask

   task automatic test_single_pulse();
      init_inputs();
      apply_reset();
      a_en = '1; a_cen = '1; a_class[2*CD +: CD] = 2'd1;
      tick();
      a_trig[2] = 1'b1;
      trig_exp_q.push_back(4'b0010);
      tick();
      a_trig[2] = 1'b0;
      trig_exp = trig_exp_q.pop_front();
      total++;
      if (a_ctrig !== trig_exp) begin
         bad++;
         $display("FAIL pulse_trig: got %b want %b", a_ctrig, trig_exp);
      end
      trig_exp_q.push_back(4'b0000);
      total++;
      if (a_cnt[1*CW +: CW] !== 4'd1) begin
         bad++;
         $display("FAIL pulse_cnt: got %0d want 1", a_cnt[1*CW +: CW]);
      end
      tick();
      trig_exp = trig_exp_q.pop_front();
      total++;
      if (a_ctrig !== trig_exp) begin
         bad++;
         $display("FAIL pulse_trig_drop: got %b want %b", a_ctrig, trig_exp);
      end
      total++;
      if (a_cause !== 4'b0100) begin
         bad++;
         $display("FAIL pulse_cause_sticky: got %b want 0100", a_cause);
      end
      total++;
      if (a_cnt !== 16'h0010) begin
         bad++;
         $display("FAIL pulse_cnt_hold: got %h want 0010", a_cnt);
      end
   endtask

   task automatic test_local();
      init_inputs();
      apply_reset();
      a_len = '1; a_cen = '1; a_lclass[5*CD +: CD] = 2'd2;
      tick();
      a_ltrig[5] = 1'b1;
      trig_exp_q.push_back(4'b0100);
      tick();
      a_ltrig = '0;
      trig_exp = trig_exp_q.pop_front();
      total++;
      if (a_ctrig !== trig_exp) begin
         bad++;
         $display("FAIL local_trig: got %b want %b", a_ctrig, trig_exp);
      end
      total++;
      if (a_lcause !== 7'b0100000 || a_cause !== 4'b0000) begin
         bad++;
         $display("FAIL local_cause: got %b/%b want 0100000/0000", a_lcause, a_cause);
      end
      total++;
      if (a_cnt !== 16'h0100) begin
         bad++;
         $display("FAIL local_cnt: got %h want 0100", a_cnt);
      end
   endtask

   task automatic test_lock();
      init_inputs();
      apply_reset();
      a_en = '1; a_cen = '1; a_class[0 +: CD] = 2'd3; a_lock = 1'b1;
      total++;
      if (a_locked !== 1'b0) begin
         bad++;
         $display("FAIL lock_before_edge: got %b want 0", a_locked);
      end
      tick();
      total++;
      if (a_locked !== 1'b1) begin
         bad++;
         $display("FAIL lock_set: got %b want 1", a_locked);
      end
      a_lock = 1'b0;
      a_class[0 +: CD] = 2'd0;
      tick();
      a_trig[0] = 1'b1;
      trig_exp_q.push_back(4'b1000);
      tick();
      a_trig = '0;
      trig_exp = trig_exp_q.pop_front();
      total++;
      if (a_ctrig !== trig_exp) begin
         bad++;
         $display("FAIL lock_frozen_class: got %b want %b", a_ctrig, trig_exp);
      end
      total++;
      if (a_cnt !== 16'h1000) begin
         bad++;
         $display("FAIL lock_cnt: got %h want 1000", a_cnt);
      end
      // Clears still act after lock.
      a_clr[0] = 1'b1; a_cclr[3] = 1'b1;
      tick();
      a_clr = '0; a_cclr = '0;
      total++;
      if (a_cause !== 4'b0000 || a_cnt !== 16'h0000 || a_locked !== 1'b1) begin
         bad++;
         $display("FAIL lock_clears: got cause=%b cnt=%h lock=%b want 0000/0000/1",
                  a_cause, a_cnt, a_locked);
      end
   endtask

   task automatic test_saturate();
      logic [CW-1:0] model;
      init_inputs();
      apply_reset();
      a_en = '1; a_cen = '1; a_class[1*CD +: CD] = 2'd0;
      tick();
      a_trig[1] = 1'b1;
      model = '0;
      for (int c = 1; c <= 20; c++) begin
         model = (model == 4'd15) ? 4'd15 : model + 4'd1;
         cnt_exp_q.push_back(model);
         tick();
         cnt_exp = cnt_exp_q.pop_front();
         total++;
         if (a_cnt[0 +: CW] !== cnt_exp || a_sat[0] !== (cnt_exp == 4'd15)) begin
            bad++;
            $display("FAIL sat_count cycle %0d: got cnt=%0d sat=%b want cnt=%0d sat=%b",
                     c, a_cnt[0 +: CW], a_sat[0], cnt_exp, (cnt_exp == 4'd15));
         end
      end
      a_cclr[0] = 1'b1;
      cnt_exp_q.push_back(4'd1);
      tick();
      cnt_exp = cnt_exp_q.pop_front();
      total++;
      if (a_cnt[0 +: CW] !== cnt_exp || a_sat[0] !== 1'b0) begin
         bad++;
         $display("FAIL sat_clr_with_hit: got cnt=%0d sat=%b want %0d/0",
                  a_cnt[0 +: CW], a_sat[0], cnt_exp);
      end
      a_trig = '0;
      cnt_exp_q.push_back(4'd0);
      tick();
      a_cclr = '0;
      cnt_exp = cnt_exp_q.pop_front();
      total++;
      if (a_cnt[0 +: CW] !== cnt_exp) begin
         bad++;
         $display("FAIL sat_clr_alone: got cnt=%0d want %0d", a_cnt[0 +: CW], cnt_exp);
      end
   endtask

   task automatic test_back_to_back();
      init_inputs();
      apply_reset();
      a_en = '1; a_cen = '1; a_class[0 +: CD] = 2'd2; a_class[3*CD +: CD] = 2'd2;
      tick();
      a_trig[0] = 1'b1; a_trig[3] = 1'b1; a_clr[0] = 1'b1;
      trig_exp_q.push_back(4'b0100);
      tick();
      a_clr = '0; a_trig[3] = 1'b0;
      trig_exp = trig_exp_q.pop_front();
      total++;
      if (a_ctrig !== trig_exp) begin
         bad++;
         $display("FAIL b2b_trig0: got %b want %b", a_ctrig, trig_exp);
      end
      total++;
      if (a_cnt[2*CW +: CW] !== 4'd1) begin
         bad++;
         $display("FAIL b2b_one_per_cycle: got %0d want 1", a_cnt[2*CW +: CW]);
      end
      total++;
      if (a_cause !== 4'b1001) begin
         bad++;
         $display("FAIL b2b_set_beats_clr: got %b want 1001", a_cause);
      end
      trig_exp_q.push_back(4'b0100);
      tick();
      a_trig = '0;
      trig_exp = trig_exp_q.pop_front();
      total++;
      if (a_ctrig !== trig_exp || a_cnt[2*CW +: CW] !== 4'd2) begin
         bad++;
         $display("FAIL b2b_second: got trig=%b cnt=%0d want %b/2",
                  a_ctrig, a_cnt[2*CW +: CW], trig_exp);
      end
      trig_exp_q.push_back(4'b0000);
      a_clr[0] = 1'b1;
      tick();
      a_clr = '0;
      trig_exp = trig_exp_q.pop_front();
      total++;
      if (a_ctrig !== trig_exp || a_cnt[2*CW +: CW] !== 4'd2) begin
         bad++;
         $display("FAIL b2b_idle: got trig=%b cnt=%0d want %b/2",
                  a_ctrig, a_cnt[2*CW +: CW], trig_exp);
      end
      total++;
      if (a_cause !== 4'b1000) begin
         bad++;
         $display("FAIL b2b_cause_clr: got %b want 1000", a_cause);
      end
   endtask

   task automatic test_class_en();
      init_inputs();
      apply_reset();
      a_en = 4'b1110; a_cen = 4'b1101; a_class[2*CD +: CD] = 2'd1;
      tick();
      a_trig[0] = 1'b1; a_trig[2] = 1'b1;
      trig_exp_q.push_back(4'b0000);
      tick();
      tick();
      a_trig = '0;
      trig_exp = trig_exp_q.pop_front();
      total++;
      if (a_ctrig !== trig_exp) begin
         bad++;
         $display("FAIL class_en_trig: got %b want %b", a_ctrig, trig_exp);
      end
      total++;
      if (a_cnt !== 16'h0000) begin
         bad++;
         $display("FAIL class_en_cnt: got %h want 0000", a_cnt);
      end
      total++;
      if (a_cause !== 4'b0100) begin
         bad++;
         $display("FAIL class_en_cause: got %b want 0100", a_cause);
      end
   endtask

   task automatic test_no_class();
      init_inputs();
      apply_reset();
      b_en = '1; b_cen = '1; b_class[1*CD +: CD] = 2'd3;
      tick();
      b_trig[1] = 1'b1;
      tick();
      b_trig = '0;
      total++;
      if (b_ctrig !== 3'b000 || b_cnt !== '0) begin
         bad++;
         $display("FAIL noclass_trig: got trig=%b cnt=%h want 000/0", b_ctrig, b_cnt);
      end
      total++;
      if (b_cause !== 4'b0010) begin
         bad++;
         $display("FAIL noclass_cause: got %b want 0010", b_cause);
      end
      b_class[1*CD +: CD] = 2'd2;
      tick();
      b_trig[1] = 1'b1;
      tick();
      b_trig = '0;
      total++;
      if (b_ctrig !== 3'b100 || b_cnt[2*CWB +: CWB] !== 16'd1) begin
         bad++;
         $display("FAIL top_class_hit: got trig=%b cnt=%0d want 100/1",
                  b_ctrig, b_cnt[2*CWB +: CWB]);
      end
   endtask

   task automatic test_reset_mid();
      init_inputs();
      apply_reset();
      a_en = '1; a_cen = '1; a_class[0 +: CD] = 2'd1; a_lock = 1'b1;
      tick();
      a_lock = 1'b0;
      a_trig[0] = 1'b1;
      repeat (7) tick();
      total++;
      if (a_cnt[1*CW +: CW] !== 4'd7 || a_locked !== 1'b1) begin
         bad++;
         $display("FAIL mid_cnt7: got cnt=%0d lock=%b want 7/1", a_cnt[1*CW +: CW], a_locked);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({a_cause, a_lcause, a_ctrig, a_cnt, a_sat} !== '0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got %h want 0",
                  {a_cause, a_lcause, a_ctrig, a_cnt, a_sat});
      end
      total++;
      if (a_locked !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_lock: got %b want 0", a_locked);
      end
      a_trig = '0;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_pulse();
      test_local();
      test_lock();
      test_saturate();
      test_back_to_back();
      test_class_en();
      test_no_class();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alert_handler_classifier.md
ALERT_HANDLER_CLASSIFIER -- requirements
Module: alert_handler_classifier

Interface
REQ-001 Parameter NAlerts, default 4: number of external alert inputs, legal 1..64.
REQ-002 Parameter NLocAlerts, default 7: number of local alert inputs, legal 1..16.
REQ-003 Parameter NClasses, default 4: number of classes, legal 2..8.
REQ-004 Parameter ClassDw, default $clog2(NClasses): class index width.
REQ-005 Parameter CntDw, default 16: per-class hit counter width, legal 4..32.
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 alert_trig_i / loc_alert_trig_i  in  NAlerts / NLocAlerts  alert trigger levels.
REQ-009 alert_en_i / loc_alert_en_i  in  NAlerts / NLocAlerts  per-alert enable (config).
REQ-010 alert_class_i / loc_alert_class_i  in  NAlerts x ClassDw / NLocAlerts x ClassDw  class assignment (config).
REQ-011 class_en_i  in  NClasses  per-class enable (config).
REQ-012 cfg_lock_i  in  1  config lock request.
REQ-013 cause_clr_i / loc_cause_clr_i  in  NAlerts / NLocAlerts  write-1-clear of sticky causes.
REQ-014 class_cnt_clr_i  in  NClasses  per-class counter clear pulse.
REQ-015 cfg_locked_o  out  1  config frozen.
REQ-016 alert_cause_o / loc_alert_cause_o  out  NAlerts / NLocAlerts  sticky cause bits.
REQ-017 class_trig_o  out  NClasses  registered class hit.
REQ-018 class_cnt_o  out  NClasses x CntDw  per-class hit count; class_cnt_sat_o  out  NClasses  counter saturated.

Function
REQ-019 Config shadow (enables, class assignments, class_en) SHALL load from inputs every cycle while cfg_locked_o=0 and hold while cfg_locked_o=1.
REQ-020 cfg_locked_o SHALL set the cycle after cfg_lock_i=1 is sampled and remain set until reset; the config sampled in that same edge is the frozen value.
REQ-021 Effective cause per alert SHALL be trig_i AND shadowed enable, combinational from trigger.
REQ-022 Sticky cause SHALL set on effective cause, clear on clr=1; simultaneous set and clear -> bit reads 1.
REQ-023 Class hit k SHALL be OR over alerts with effective cause whose shadowed class equals k, ANDed with shadowed class_en[k].
REQ-024 Class index >= NClasses SHALL map to no class; sticky cause still records.
REQ-025 class_trig_o[k] SHALL equal class hit k delayed by exactly 1 cycle, level per cycle (no edge detect).
REQ-026 Counter k SHALL increment by 1 per cycle with class hit k (not per alert), saturating at 2^CntDw-1.
REQ-027 class_cnt_sat_o[k] SHALL be 1 iff counter k equals 2^CntDw-1.
REQ-028 Clear and hit in same cycle SHALL yield count 1; clear alone yields 0; clear clears saturation.
REQ-029 Clears and counters SHALL operate identically before and after lock.

Reset
REQ-030 On rst_ni=0, all outputs, sticky causes, counters, shadow config and lock SHALL go to 0 asynchronously.
REQ-031 After reset release, first class_trig_o assertion SHALL occur no earlier than the second rising edge (shadow load then hit register).

Structure
REQ-032 NClasses-dependent typedefs (class index type, counter type) SHALL live in alert_pkg; defaults of N-parameters SHALL derive from alert_pkg constants.
REQ-033 Per-class saturating counter with clear SHALL be sub-module alert_handler_class_cnt, instantiated NClasses times.

Verification
REQ-034 Reset, en all 1, alert 2 class 1, pulse alert_trig_i[2] one cycle at edge n -> class_trig_o=4'b0010 for cycle n+1 only, alert_cause_o[2]=1 sticky, class_cnt_o[1]=1.
REQ-035 Config alert 0 class 3, assert cfg_lock_i, then change alert_class_i[0]=0 -> trigger alert 0 hits class 3, cfg_locked_o=1.
REQ-036 CntDw=4, hold alert 1 (class 0) 20 cycles -> class_cnt_o[0]=15, class_cnt_sat_o[0]=1; then class_cnt_clr_i[0] with hit -> count 1, sat 0.
REQ-037 Alerts 0 and 3 both class 2 fire in same cycle -> count increments by 1; cause_clr_i[0] same cycle as trigger -> alert_cause_o[0] stays 1.
REQ-038 NClasses=3, alert assigned class 3 fires -> no class_trig_o bit, cause recorded; class_en_i[k]=0 -> class k never triggers or counts.
REQ-039 Assert rst_ni mid-count (count 7, lock set) -> all outputs 0 immediately, cfg_locked_o=0.
